// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers and counter range constants shared by the Gray counter and FIFO pointer logic.
// Functions work on MAX_W-bit zero-extended values; callers truncate to their own width.
package gray_pkg;

  localparam int MAX_W         = 32;
  localparam int DEFAULT_WIDTH = 4;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] cnt_max(input int w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] cnt_min();
    return '0;
  endfunction

endpackage

// File: rtl/gray_counter_ud_gray2bin.sv
// Combinational Gray-to-binary converter, WIDTH-generic; reusable for synchronised FIFO pointers.
// Zero latency, no flow control: each binary bit is the XOR of all Gray bits at or above it.
module gray_counter_ud_gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with sync load, look-ahead gray_next and terminal-count pulse; 1-cycle step latency, no backpressure.
// Define GRAY_COUNTER_SAT_EN for saturating mode (count holds at the ends, tc stays high); default wraps.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_gray,
  output logic [WIDTH-1:0] o_gray_out,
  output logic [WIDTH-1:0] o_bin_out,
  output logic [WIDTH-1:0] o_gray_next,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] CNT_MIN    = WIDTH'(cnt_min());
  localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(MAX_W'(RESET_BIN)));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_tc_nxt;
  logic             w_at_max;
  logic             w_at_min;

  gray_counter_ud_gray2bin #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .i_gray (i_load_gray),
    .o_bin  (w_load_bin)
  );

  assign w_at_max = (r_bin == CNT_MAX);
  assign w_at_min = (r_bin == CNT_MIN);

  // Single binary next-state mux; reset is folded in so gray_next is valid during reset.
  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (!i_rst_n) begin
      w_bin_nxt = RESET_BIN;
    end else if (i_load) begin
      w_bin_nxt = w_load_bin;
    end else if (i_en) begin
      if (i_up) begin
`ifdef GRAY_COUNTER_SAT_EN
        if (w_at_max) begin
          w_bin_nxt = r_bin;
          w_tc_nxt  = 1'b1;
        end else begin
          w_bin_nxt = r_bin + WIDTH'(1);
        end
`else
        w_bin_nxt = r_bin + WIDTH'(1);
        w_tc_nxt  = w_at_max;
`endif
      end else begin
`ifdef GRAY_COUNTER_SAT_EN
        if (w_at_min) begin
          w_bin_nxt = r_bin;
          w_tc_nxt  = 1'b1;
        end else begin
          w_bin_nxt = r_bin - WIDTH'(1);
        end
`else
        w_bin_nxt = r_bin - WIDTH'(1);
        w_tc_nxt  = w_at_min;
`endif
      end
    end
  end

  assign w_gray_nxt = WIDTH'(bin2gray(MAX_W'(w_bin_nxt)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bin  <= RESET_BIN;
      r_gray <= RESET_GRAY;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign o_gray_out  = r_gray;
  assign o_bin_out   = r_bin;
  assign o_gray_next = w_gray_nxt;
  assign o_tc        = r_tc;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Self-checking bench for gray_counter_ud (WIDTH=4): vector table, corner sequences, random run vs integer model.
module tb_gray_counter_ud;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_gray;
  logic [3:0] gray_out, bin_out, gray_next;
  logic       tc;
  logic [3:0] gray_out9, bin_out9, gray_next9;
  logic       tc9;

  int n_checks = 0;
  int n_err    = 0;
  int m_bin    = 0;

  gray_counter_ud #(.WIDTH(4), .RESET_VALUE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load),
    .i_load_gray(load_gray), .o_gray_out(gray_out), .o_bin_out(bin_out),
    .o_gray_next(gray_next), .o_tc(tc)
  );

  gray_counter_ud #(.WIDTH(4), .RESET_VALUE(9)) dut9 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load),
    .i_load_gray(load_gray), .o_gray_out(gray_out9), .o_bin_out(bin_out9),
    .o_gray_next(gray_next9), .o_tc(tc9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lg;
    logic [3:0] exp_gray;
    logic [3:0] exp_bin;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[20];

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search over the code space rather than by a prefix-XOR formula.
  function automatic int g2b(input int g);
    for (int b = 0; b < 16; b++) begin
      if (b2g(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: plain integer count with wrap (or clamp) arithmetic.
  task automatic predict(output int nb, output int ntc);
    nb  = m_bin;
    ntc = 0;
    if (!rst_n) begin
      nb = 0;
    end else if (load) begin
      nb = g2b(int'(load_gray));
    end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (up) begin
        if (m_bin == 15) ntc = 1; else nb = m_bin + 1;
      end else begin
        if (m_bin == 0) ntc = 1; else nb = m_bin - 1;
      end
`else
      if (up) begin
        ntc = (m_bin + 1 > 15) ? 1 : 0;
        nb  = (m_bin + 1) % 16;
      end else begin
        ntc = (m_bin - 1 < 0) ? 1 : 0;
        nb  = (m_bin + 15) % 16;
      end
`endif
    end
  endtask

  // Apply one cycle of inputs, check look-ahead before the edge and registers after it.
  task automatic cycle(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] lg);
    int nb, ntc;
    rst_n = r; load = l; en = e; up = u; load_gray = lg;
    #1;
    predict(nb, ntc);
    check("gray_next", int'(gray_next), b2g(nb));
    @(posedge clk);
    #1;
    m_bin = nb;
    check("gray_out", int'(gray_out), b2g(nb));
    check("bin_out", int'(bin_out), nb);
    check("tc", int'(tc), ntc);
    check("bin_is_gray2bin", int'(bin_out), g2b(int'(gray_out)));
  endtask

  initial begin : main
    logic [3:0] gseq [16];
    logic [3:0] prev_gray;
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    for (int i = 1; i <= 16; i++) begin
      vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, gseq[i-1], 4'(i % 16), (i == 16)};
    end
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'h5, 4'h6, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h5, 4'h6, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h7, 4'h5, 1'b0};

    rst_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_gray = 4'h0;
    @(posedge clk);
    #1;

    prev_gray = 4'h0;
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst_n, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lg);
      check($sformatf("vec%0d_gray", i), int'(gray_out), int'(vecs[i].exp_gray));
      check($sformatf("vec%0d_bin", i), int'(bin_out), int'(vecs[i].exp_bin));
      check($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
      if (i == 0) begin
        check("reset9_gray", int'(gray_out9), 'hD);
        check("reset9_bin", int'(bin_out9), 9);
        check("reset9_tc", int'(tc9), 0);
      end
      if (i >= 1 && i <= 16) begin
        check($sformatf("onebit_step%0d", i), $countones(prev_gray ^ gray_out), 1);
      end
      prev_gray = gray_out;
    end

    // Load 8 (Gray C) then count down through zero into the wrap.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
    check("load_c_bin", int'(bin_out), 8);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      check($sformatf("down%0d_bin", k), int'(bin_out), (k == 9) ? 15 : 8 - k);
      check($sformatf("down%0d_tc", k), int'(tc), (k == 9) ? 1 : 0);
      if (k == 1) check("down_gray_at7", int'(gray_out), 4);
    end

    // Reset while stepping at bin 5; reset also beats a simultaneous load.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
    check("at5_bin", int'(bin_out), 5);
    rst_n = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; #1;
    check("rst_gray_next9", int'(gray_next9), 'hD);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    check("midrst_bin", int'(bin_out), 0);
    check("midrst_gray", int'(gray_out), 0);
    check("midrst_tc", int'(tc), 0);
    check("midrst9_gray", int'(gray_out9), 'hD);
    check("midrst9_bin", int'(bin_out9), 9);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF);
    check("rst_over_load_bin", int'(bin_out), 0);

    for (int c = 0; c < 10000; c++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
